alu_operand_seq: RTL

Upstream operand sequencer for the 4-bit ALU datapath. Collects operand A, operand B and the 3-bit operation select from one shared 4-bit input channel over three valid/ready transfers. Then holds them stable on registered outputs and presents them to the complement/ALU stage with an output valid/ready handshake. Also counts completed operations and flags malformed opcode nibbles.

---
 rtl/alu_pkg.sv | 41 ++++
 rtl/alu_operand_seq.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared definitions for the 4-bit ALU datapath: operation
//                select codes, operand-sequencer state encoding, default
//                widths and a helper that identifies the codes needing the
//                two's complement of operand B.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

    // Default widths
    localparam int DEF_WIDTH = 4;   // operand width
    localparam int DEF_OPW   = 3;   // operation select width
    localparam int DEF_CNTW  = 8;   // issued-operation counter width

    // Operation select encoding
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_NOT = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_LT  = 3'b110;
    localparam logic [2:0] OP_EQ  = 3'b111;

    // Operand sequencer states
    typedef enum logic [1:0] {
        S_A   = 2'd0,   // capture operand A
        S_B   = 2'd1,   // capture operand B
        S_OP  = 2'd2,   // capture operation select
        S_OUT = 2'd3    // present the completed operation
    } seq_state_t;

    // Codes for which the downstream stage works on -b rather than b
    function automatic logic op_uses_b_neg(input logic [2:0] op);
        return (op == OP_SUB) || (op == OP_LT) || (op == OP_EQ);
    endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_operand_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_operand_seq
//  Description : Operand sequencer in front of the complement/ALU stage.
//                Collects operand A, operand B and the operation select over
//                three valid/ready transfers on one shared nibble channel,
//                then holds them on registered outputs until the downstream
//                stage accepts them. Counts accepted operations and pulses
//                op_err when an opcode nibble has non-zero upper bits.
//  Ports       : clk, rst_n (async, active-low), clr (sync abort)
//                in_valid/in_ready/in_data  : nibble input channel
//                a, b, option               : registered operation fields
//                out_valid/out_ready        : operation output handshake
//                op_err                     : rejected-opcode pulse
//                op_cnt                     : consumed-operation counter
//  Revision    : 1.0  initial release
// ============================================================================
module alu_operand_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int OPW   = DEF_OPW,
    parameter int CNTW  = DEF_CNTW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [OPW-1:0]   option,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             op_err,
    output logic [CNTW-1:0]  op_cnt
);

    seq_state_t        r_state;
    seq_state_t        w_next_state;
    logic              r_op_err;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [OPW-1:0]    r_option;
    logic [CNTW-1:0]   r_op_cnt;

    logic              w_in_xfer;
    logic              w_out_xfer;
    logic              w_op_legal;
    logic              w_cap_a;
    logic              w_cap_b;
    logic              w_cap_op;
    logic              w_op_err_nxt;
    logic              w_cnt_inc;

    // Handshake flags are decodes of registered state only, so no input
    // reaches an output combinationally.
    assign in_ready   = (r_state != S_OUT);
    assign out_valid  = (r_state == S_OUT);
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = out_valid && out_ready;

    // An opcode nibble is only legal when the bits above the select field are zero
    assign w_op_legal = (in_data[WIDTH-1:OPW] == '0);

    // ------------------------------------------------------------------
    // Next-state and strobe decode
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_cap_a      = 1'b0;
        w_cap_b      = 1'b0;
        w_cap_op     = 1'b0;
        w_op_err_nxt = 1'b0;
        w_cnt_inc    = 1'b0;

        if (clr) begin
            // Abort wins over every handshake: nothing is captured or counted
            w_next_state = S_A;
        end else begin
            unique case (r_state)
                S_A: begin
                    if (w_in_xfer) begin
                        w_cap_a      = 1'b1;
                        w_next_state = S_B;
                    end
                end
                S_B: begin
                    if (w_in_xfer) begin
                        w_cap_b      = 1'b1;
                        w_next_state = S_OP;
                    end
                end
                S_OP: begin
                    if (w_in_xfer) begin
                        if (w_op_legal) begin
                            w_cap_op     = 1'b1;
                            w_next_state = S_OUT;
                        end else begin
                            // Rejected nibble: remain here and keep the old select
                            w_op_err_nxt = 1'b1;
                        end
                    end
                end
                S_OUT: begin
                    if (w_out_xfer) begin
                        w_cnt_inc    = 1'b1;
                        w_next_state = S_A;
                    end
                end
                default: w_next_state = S_A;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State register and error pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_A;
            r_op_err <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_op_err <= w_op_err_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Capture registers: hold their value after the operation is consumed
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_option <= '0;
        end else begin
            if (w_cap_a)  r_a      <= in_data;
            if (w_cap_b)  r_b      <= in_data;
            if (w_cap_op) r_option <= in_data[OPW-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Consumed-operation counter, wraps modulo 2^CNTW
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_cnt <= '0;
        end else if (w_cnt_inc) begin
            r_op_cnt <= r_op_cnt + CNTW'(1);
        end
    end

    assign a      = r_a;
    assign b      = r_b;
    assign option = r_option;
    assign op_err = r_op_err;
    assign op_cnt = r_op_cnt;

endmodule : alu_operand_seq
`default_nettype wire
